// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use / multi-cycle / redirect
// stall sequencing for the 5-stage core, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_mc,
  input  logic [4:0]       e_rn,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [4:0]       m_rn,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic             redirect,
  input  logic             mc_done,
  output logic             wpcir,
  output logic             de_clear,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mc_go,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       flush_q, flush_d;
  logic             mc_go_q, mc_go_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             wp, dc, load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] x);
    logic [1:0] s;
    s = 2'b00;
    if (x != 5'd0) begin
      if (e_wreg && !e_m2reg && e_rn == x) s = 2'b01;
      else if (m_wreg && m_rn == x)        s = m_m2reg ? 2'b11 : 2'b10;
    end
    return s;
  endfunction

  assign load_use = e_wreg && e_m2reg && (e_rn != 5'd0) &&
                    ((d_use_rs && d_rs == e_rn) || (d_use_rt && d_rt == e_rn));

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    mc_go_d = 1'b0;
    wp      = 1'b1;
    dc      = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          dc      = 1'b1;
          flush_d = FLUSH_LOAD;
          state_d = FLUSH;
        end else if (load_use) begin
          wp = 1'b0;
          dc = 1'b1;
        end else if (d_mc) begin
          wp      = 1'b0;
          dc      = 1'b1;
          mc_go_d = 1'b1;
          state_d = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_d = RUN;
        end else begin
          wp = 1'b0;
          dc = 1'b1;
        end
      end
      FLUSH: begin
        dc      = 1'b1;
        flush_d = redirect ? FLUSH_LOAD : flush_q - 3'd1;
        if (flush_d == 3'd0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    stall_d = (!wp && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flush_q <= '0;
      mc_go_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      mc_go_q <= mc_go_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces a bubble and regfile operands independent of the registered state.
  assign wpcir     = rst_n && wp;
  assign de_clear  = !rst_n || dc;
  assign fwda      = rst_n ? fwd_sel(d_rs) : 2'b00;
  assign fwdb      = rst_n ? fwd_sel(d_rt) : 2'b00;
  assign mc_go     = mc_go_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two hazard_ctrl instances (FLUSH_CYCLES 1/3, CNT_W 16/4) share stimulus
// and are compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_rs, d_rt, e_rn, m_rn;
  logic       d_use_rs, d_use_rt, d_mc, e_wreg, e_m2reg, m_wreg, m_m2reg, redirect, mc_done;

  logic        wp_o [2];
  logic        dc_o [2];
  logic [1:0]  fa_o [2];
  logic [1:0]  fb_o [2];
  logic        go_o [2];
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state, one slot per instance
  int unsigned FC   [2] = '{1, 3};
  int unsigned MAXC [2] = '{65535, 15};
  int unsigned flush_left [2];
  bit          busy [2];
  bit          go   [2];
  int unsigned stalls [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_mc(d_mc), .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .m_rn(m_rn), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .redirect(redirect), .mc_done(mc_done), .wpcir(wp_o[0]), .de_clear(dc_o[0]),
    .fwda(fa_o[0]), .fwdb(fb_o[0]), .mc_go(go_o[0]), .stall_cnt(stall_a)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_mc(d_mc), .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .m_rn(m_rn), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .redirect(redirect), .mc_done(mc_done), .wpcir(wp_o[1]), .de_clear(dc_o[1]),
    .fwda(fa_o[1]), .fwdb(fb_o[1]), .mc_go(go_o[1]), .stall_cnt(stall_b)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_fwd(input int unsigned x);
    if (x == 0) return 0;
    if (e_wreg && !e_m2reg && e_rn == x) return 1;
    if (m_wreg && m_rn == x) return m_m2reg ? 3 : 2;
    return 0;
  endfunction

  task automatic clear_inputs();
    {d_rs, d_rt, e_rn, m_rn} = '0;
    {d_use_rs, d_use_rt, d_mc, e_wreg, e_m2reg, m_wreg, m_m2reg, redirect, mc_done} = '0;
  endtask

  // Called just after a falling edge with inputs already applied; checks, advances model,
  // and returns just after the next falling edge.
  task automatic step();
    bit          lu, ewp, edc, nbusy, ngo;
    int unsigned efa, efb, nflush, nst, gst;
    #1;
    if (!rst_n)
      for (int k = 0; k < 2; k++) begin
        flush_left[k] = 0; busy[k] = 0; go[k] = 0; stalls[k] = 0;
      end
    assert (!(redirect && rst_n && (busy[0] || busy[1])));
    lu  = e_wreg && e_m2reg && e_rn != 0 &&
          ((d_use_rs && d_rs == e_rn) || (d_use_rt && d_rt == e_rn));
    for (int k = 0; k < 2; k++) begin
      nflush = flush_left[k]; nbusy = busy[k]; ngo = 0;
      efa = ref_fwd(d_rs); efb = ref_fwd(d_rt);
      if (!rst_n) begin
        ewp = 0; edc = 1; efa = 0; efb = 0;
      end else if (flush_left[k] > 0) begin
        ewp = 1; edc = 1; nflush = redirect ? FC[k] : flush_left[k] - 1;
      end else if (busy[k]) begin
        ewp = mc_done; edc = !mc_done; nbusy = !mc_done;
      end else if (redirect) begin
        ewp = 1; edc = 1; nflush = FC[k];
      end else if (lu) begin
        ewp = 0; edc = 1;
      end else if (d_mc) begin
        ewp = 0; edc = 1; nbusy = 1; ngo = 1;
      end else begin
        ewp = 1; edc = 0;
      end
      gst = (k == 0) ? 32'(stall_a) : 32'(stall_b);
      check($sformatf("wpcir%0d", k), 32'(wp_o[k]), 32'(ewp));
      check($sformatf("de_clear%0d", k), 32'(dc_o[k]), 32'(edc));
      check($sformatf("fwda%0d", k), 32'(fa_o[k]), efa);
      check($sformatf("fwdb%0d", k), 32'(fb_o[k]), efb);
      check($sformatf("mc_go%0d", k), 32'(go_o[k]), 32'(go[k]));
      check($sformatf("stall_cnt%0d", k), gst, stalls[k]);
      if (rst_n) begin
        nst = (!ewp && stalls[k] < MAXC[k]) ? stalls[k] + 1 : stalls[k];
        flush_left[k] = nflush; busy[k] = nbusy; go[k] = ngo; stalls[k] = nst;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned s0;
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    step();

    // Forwarding priorities
    e_rn = 5; e_wreg = 1; d_rs = 5;
    #1 check("fwd_e", 32'(fa_o[0]), 1);
    step();
    m_rn = 5; m_wreg = 1;
    step();
    clear_inputs(); d_rt = 7; m_rn = 7; m_wreg = 1; m_m2reg = 1;
    #1 check("fwd_mload", 32'(fb_o[0]), 3);
    step();
    clear_inputs(); e_wreg = 1;
    step();

    // Load-use then M-load forwarding
    clear_inputs(); e_rn = 3; e_wreg = 1; e_m2reg = 1; d_rt = 3; d_use_rt = 1;
    s0 = stall_a;
    step();
    clear_inputs(); d_rt = 3; d_use_rt = 1; m_rn = 3; m_wreg = 1; m_m2reg = 1;
    step();
    check("lu_stall_delta", stall_a - s0, 1);

    // Multi-cycle handshake
    clear_inputs(); s0 = stall_a; d_mc = 1;
    step();
    d_mc = 0;
    repeat (4) step();
    mc_done = 1;
    step();
    mc_done = 0;
    step();
    check("mc_stall_delta", stall_a - s0, 5);

    // Redirect flush length per instance
    redirect = 1;
    step();
    redirect = 0;
    repeat (5) step();

    // Redirect wins over load-use and mc
    e_rn = 4; e_wreg = 1; e_m2reg = 1; d_rs = 4; d_use_rs = 1; d_mc = 1; redirect = 1;
    step();
    clear_inputs();
    repeat (5) step();

    // Reset during MC_WAIT, then mc_done ignored
    d_mc = 1;
    step();
    d_mc = 0;
    step(); step();
    rst_n = 0;
    step();
    rst_n = 1; mc_done = 1;
    step();
    mc_done = 0;
    step();

    // Saturation of the 4-bit counter
    rst_n = 0;
    step();
    rst_n = 1; e_rn = 3; e_wreg = 1; e_m2reg = 1; d_rt = 3; d_use_rt = 1;
    repeat (20) step();
    check("sat_b", 32'(stall_b), 15);
    check("nosat_a", 32'(stall_a), 20);
    clear_inputs();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_rs = 5'($urandom_range(0, 7)); d_rt = 5'($urandom_range(0, 7));
      e_rn = 5'($urandom_range(0, 7)); m_rn = 5'($urandom_range(0, 7));
      d_use_rs = 1'($urandom); d_use_rt = 1'($urandom);
      e_wreg = 1'($urandom); e_m2reg = 1'($urandom);
      m_wreg = 1'($urandom); m_m2reg = 1'($urandom);
      d_mc    = ($urandom_range(0, 7) == 0);
      mc_done = ($urandom_range(0, 3) == 0);
      redirect = !(busy[0] || busy[1]) && ($urandom_range(0, 9) == 0);
      rst_n   = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n = 1;
    clear_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives the D/E pipeline register's clear input and the PC / IF-D write enable.
- Generates ALU operand forwarding selects.
- Sequences stalls for load-use hazards, multi-cycle execute ops (mul/div handshake) and taken-branch/jump redirects, and keeps a saturating stall-cycle counter.

Parameters:
FLUSH_CYCLES, 1, extra cycles after the redirect cycle during which D/E is cleared (1..7)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_rs  in  5  source reg A of instruction in D
d_rt  in  5  source reg B of instruction in D
d_use_rs  in  1  D instruction reads rs
d_use_rt  in  1  D instruction reads rt
d_mc  in  1  D instruction is a multi-cycle op
e_rn  in  5  dest reg in E
e_wreg  in  1  E writes regfile
e_m2reg  in  1  E is a load
m_rn  in  5  dest reg in M
m_wreg  in  1  M writes regfile
m_m2reg  in  1  M is a load
redirect  in  1  taken branch/jump resolved in E this cycle
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
wpcir  out  1  1 = PC and IF/D registers update
de_clear  out  1  1 = D/E register loads bubble
fwda  out  2  operand A select: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M load data
fwdb  out  2  operand B select, same encoding
mc_go  out  1  start pulse to multi-cycle unit
stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, flush counter=0, stall_cnt=0, mc_go=0.
- While rst_n is low: wpcir=0, de_clear=1, fwda=fwdb=00.
- Forwarding (combinational, per operand X in {rs,rt}):
  - X==0 gives 00.
  - Else if e_wreg && !e_m2reg && e_rn==X: 01.
  - Else if m_wreg && m_rn==X: 10, or 11 when m_m2reg.
  - Else 00. E match has priority over M.
  - Active in all states.
- load_use = e_wreg && e_m2reg && e_rn!=0 && ((d_use_rs && d_rs==e_rn) || (d_use_rt && d_rt==e_rn)).
- FSM states RUN, MC_WAIT, FLUSH. Outputs wpcir/de_clear are Mealy; mc_go is registered.
- RUN, evaluated in priority order:
  - redirect: wpcir=1, de_clear=1, load flush counter=FLUSH_CYCLES, next=FLUSH.
  - else load_use: wpcir=0, de_clear=1, stay RUN. One bubble; the next cycle forwards from M with 11.
  - else d_mc: wpcir=0, de_clear=1, mc_go=1 next cycle (one pulse), next=MC_WAIT.
  - else: wpcir=1, de_clear=0.
- MC_WAIT:
  - mc_done=0: wpcir=0, de_clear=1.
  - mc_done=1: wpcir=1, de_clear=0, next=RUN. The mc instruction advances into E this cycle and does not retrigger.
  - redirect and d_mc are ignored in MC_WAIT; E holds bubbles, so redirect cannot legally occur. The bench asserts this.
- FLUSH:
  - wpcir=1, de_clear=1, counter decrements each cycle.
  - Counter reaching 0 at the end of a cycle gives next=RUN.
  - A redirect in FLUSH reloads the counter.
  - load_use and d_mc are ignored.
- mc_done seen outside MC_WAIT is ignored.
- stall_cnt increments on every clock with wpcir=0 and saturates at all-ones.
- Reset asserted mid-MC_WAIT or mid-FLUSH returns to RUN immediately. No mc_go is reissued.

Test Plan:
- Forwarding:
  - e_rn=5, e_wreg=1, e_m2reg=0, d_rs=5 → fwda=01.
  - Same E values with m_rn=5, m_wreg=1 → still 01.
  - d_rt=7, m_rn=7, m_wreg=1, m_m2reg=1 → fwdb=11.
  - d_rs=0 with e_rn=0, e_wreg=1 → fwda=00.
- Load-use:
  - e_rn=3, e_wreg=1, e_m2reg=1, d_rt=3, d_use_rt=1 → exactly one cycle wpcir=0, de_clear=1.
  - Next cycle, with m_rn=3, m_m2reg=1 → fwdb=11, wpcir=1.
  - stall_cnt increments by 1.
- Multi-cycle:
  - d_mc=1 in RUN → mc_go pulses one cycle later.
  - wpcir=0 and de_clear=1 until mc_done is driven 4 cycles later.
  - On the mc_done cycle: wpcir=1, de_clear=0.
  - stall_cnt=+5.
- Redirect with FLUSH_CYCLES=1:
  - redirect=1 → de_clear=1 for exactly 2 cycles, wpcir=1 throughout, then RUN.
  - Repeat with FLUSH_CYCLES=3 → de_clear held for 4 cycles.
- Priority:
  - redirect=1 together with load_use and d_mc in the same cycle → redirect path taken, mc_go never pulses.
- Reset and saturation:
  - rst_n low during MC_WAIT → immediate wpcir=0, de_clear=1, stall_cnt=0.
  - After release, state is RUN and mc_done is ignored.
  - With CNT_W=4, 20 stall cycles → stall_cnt=15.
